div_unit: RTL and testbench

//  Multicycle signed 32-bit integer divider. It is the responder on the control unit's

---
 rtl/cpu_arith_pkg.sv | 24 ++
 rtl/div_step.sv | 30 +++
 rtl/div_unit.sv | 149 ++++++++++++++
 tb/tb_div_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_arith_pkg.sv
// Shared definitions for the multicycle arithmetic units (divider and multiplier).
// Holds the divider state encoding, iteration constants and a small state helper.
package cpu_arith_pkg;

  // One restoring step per operand bit.
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITER);

  // Divider sequencing states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // True while an accepted operation is still being worked on.
  // DONE is not busy: the done pulse is being issued from it.
  function automatic logic div_state_busy(input div_state_t s);
    return (s == LOAD) || (s == RUN) || (s == FIX);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Shifts the next dividend bit into the partial remainder, trial-subtracts the
// divisor and shifts the resulting quotient bit into the quotient LSB.
module div_step
  import cpu_arith_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Trial subtraction. The incoming remainder is always below the divisor, so the
  // shifted value needs one extra bit and any accepted difference fits in WIDTH bits.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    fits    = (shifted >= divisor);
    diff    = shifted[WIDTH-1:0] - divisor[WIDTH-1:0];
    rem_out = fits ? diff : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle 32-bit integer divider, responder on the control unit's start/done
// handshake. Quotient goes to lo_out, remainder to hi_out, and a zero divisor is
// reported on div_zero alongside the done pulse.
// Optional build macro DIV_UNSIGNED_EN adds the div_unsigned input for divu.
module div_unit
  import cpu_arith_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_control,
`ifdef DIV_UNSIGNED_EN
  input  logic             div_unsigned,
`endif
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_end,
  output logic             div_zero,
  output logic             div_busy
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Operands captured on the accepting edge; the control unit may change A/B afterwards.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             uns_q;
  logic             uns_in;

  // Working registers. The divisor magnitude carries an extra bit so that the
  // magnitude of the most negative value never overflows.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             zero_q;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH:0]   abs_b;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

`ifdef DIV_UNSIGNED_EN
  assign uns_in = div_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  // Sign handling is suppressed for unsigned operations so no abs/negate takes place.
  // The magnitude of 0x80000000 is 0x80000000 read as unsigned, which fits.
  always_comb begin
    sign_a = a_q[WIDTH-1] & ~uns_q;
    sign_b = b_q[WIDTH-1] & ~uns_q;
    abs_a  = sign_a ? -a_q : a_q;
    abs_b  = {1'b0, (sign_b ? -b_q : b_q)};
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign div_busy = div_state_busy(state);

  // Sequencer and datapath: capture, magnitude load, 32 restoring steps, sign fix-up,
  // then a single done pulse. hi_out/lo_out are only ever written in FIX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      uns_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      div_end   <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      div_end  <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (div_control) begin
            a_q   <= A_in;
            b_q   <= B_in;
            uns_q <= uns_in;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (b_q == '0) begin
            zero_q <= 1'b1;
            state  <= DONE;
          end else begin
            zero_q    <= 1'b0;
            quo_q     <= abs_a;
            dvs_q     <= abs_b;
            rem_q     <= '0;
            neg_quo_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            cnt       <= CNT_W'(WIDTH - 1);
            state     <= RUN;
          end
        end
        RUN: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          lo_out <= neg_quo_q ? -quo_q : quo_q;
          hi_out <= neg_rem_q ? -rem_q : rem_q;
          state  <= DONE;
        end
        DONE: begin
          div_end  <= 1'b1;
          div_zero <= zero_q;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit with hand-computed expected quotients/remainders.
// Build with DIV_UNSIGNED_EN defined to exercise the divu path as well.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_control;
  logic        div_unsigned;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_end;
  logic        div_zero;
  logic        div_busy;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .div_control (div_control),
`ifdef DIV_UNSIGNED_EN
    .div_unsigned(div_unsigned),
`endif
    .A_in        (A_in),
    .B_in        (B_in),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_end     (div_end),
    .div_zero    (div_zero),
    .div_busy    (div_busy)
  );

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Request one operation; returns 1ns after the accepting edge with the operands scrambled.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic uns);
    @(negedge clk);
    A_in         = a;
    B_in         = b;
    div_unsigned = uns;
    div_control  = 1'b1;
    @(posedge clk);
    #1;
    div_control  = 1'b0;
    div_unsigned = ~uns;
    A_in         = $urandom;
    B_in         = $urandom | 32'h1;
  endtask

  // Counts edges after the accepting edge until div_end is seen (bounded).
  task automatic waitDone(output int edges);
    bit found;
    found = 1'b0;
    edges = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (div_end) found = 1'b1;
    end
    checkOutput("done_seen", 32'(found), 32'd1);
  endtask

  // Full normal operation: busy, latency (done visible after the 35th edge past start),
  // results, and single-cycle done pulse.
  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic uns, input logic [31:0] expLo, input logic [31:0] expHi);
    int edges;
    applyStimulus(a, b, uns);
    checkOutput({tag, "_busy"}, 32'(div_busy), 32'd1);
    waitDone(edges);
    checkOutput({tag, "_lat"}, 32'(edges), 32'd35);
    checkOutput({tag, "_lo"}, lo_out, expLo);
    checkOutput({tag, "_hi"}, hi_out, expHi);
    checkOutput({tag, "_zero"}, 32'(div_zero), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_endclr"}, 32'(div_end), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;
    int pulses;

    reset        = 1'b0;
    div_control  = 1'b0;
    div_unsigned = 1'b0;
    A_in         = '0;
    B_in         = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hi", hi_out, 32'h0);
    checkOutput("rst_lo", lo_out, 32'h0);
    checkOutput("rst_end", 32'(div_end), 32'd0);
    checkOutput("rst_zero", 32'(div_zero), 32'd0);
    checkOutput("rst_busy", 32'(div_busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    runDiv("p100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    runDiv("m100_7", 32'hFFFFFF9C, 32'd7, 1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE);
    runDiv("p100_m7", 32'd100, 32'hFFFFFFF9, 1'b0, 32'hFFFFFFF2, 32'd2);
    runDiv("m1_2", 32'hFFFFFFFF, 32'd2, 1'b0, 32'h0, 32'hFFFFFFFF);

    // 0x12345678 / 0x10000 leaves lo=0x1234, hi=0x5678 as the prior results.
    runDiv("prior", 32'h12345678, 32'h00010000, 1'b0, 32'h1234, 32'h5678);
    applyStimulus(32'd7, 32'd0, 1'b0);
    waitDone(edges);
    checkOutput("dz_lat", 32'(edges), 32'd2);
    checkOutput("dz_zero", 32'(div_zero), 32'd1);
    checkOutput("dz_lo", lo_out, 32'h1234);
    checkOutput("dz_hi", hi_out, 32'h5678);
    @(posedge clk);
    #1;
    checkOutput("dz_endclr", 32'(div_end), 32'd0);
    checkOutput("dz_zeroclr", 32'(div_zero), 32'd0);

    runDiv("minneg", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'h0);

    // Abort in the middle of RUN.
    applyStimulus(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("abort_hi", hi_out, 32'h0);
    checkOutput("abort_lo", lo_out, 32'h0);
    checkOutput("abort_busy", 32'(div_busy), 32'd0);
    checkOutput("abort_end", 32'(div_end), 32'd0);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (div_end) pulses++;
    end
    checkOutput("abort_noend", 32'(pulses), 32'd0);
    runDiv("after_abort", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

    // Extra requests while busy (cycle 5) and while in DONE (cycle 35) are ignored.
    applyStimulus(32'd100, 32'd7, 1'b0);
    pulses = 0;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      div_control = (i == 5) || (i == 35);
      A_in        = 32'd50;
      B_in        = 32'd5;
      @(posedge clk);
      #1;
      if (div_end) pulses++;
    end
    div_control = 1'b0;
    checkOutput("ign_pulses", 32'(pulses), 32'd1);
    checkOutput("ign_lo", lo_out, 32'd14);
    checkOutput("ign_hi", hi_out, 32'd2);
    checkOutput("ign_idle", 32'(div_busy), 32'd0);

`ifdef DIV_UNSIGNED_EN
    runDiv("divu", 32'hFFFFFFFF, 32'd2, 1'b1, 32'h7FFFFFFF, 32'd1);
    runDiv("divu_min", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
